// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port data RAM arbiter.
// Port 0 is the CPU load/store unit, port 1 the DMA engine.
package ram_arb_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 10;
    localparam int unsigned DATA_W_DEFAULT = 8;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StAck
    } arb_state_e;

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin picker; owns the last-served flop, which favours port 0 after reset.
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       valid
);

    logic last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= PORT_DMA;
        end else if (update) begin
            last_q <= grant;
        end
    end

    always_comb begin
        valid = |req;
        // Under contention the port not served last wins; otherwise the lone requester.
        if (&req) begin
            grant = ~last_q;
        end else begin
            grant = req[1];
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a single-port RAM between CPU and DMA: one 3-cycle access at a time
// (IDLE -> ACCESS -> ACK), all outputs driven from registers.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              ram_enable,
    output logic              ram_str,
    output logic              ram_ldr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              en_q, en_d;
    logic              str_q, str_d;
    logic              ldr_q, ldr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;

    logic              grant;
    logic              grant_valid;
    logic              grant_upd;
    logic              sel_we;

    ram_arb_rr2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({req1, req0}),
        .update (grant_upd),
        .grant  (grant),
        .valid  (grant_valid)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        en_d      = 1'b0;
        str_d     = 1'b0;
        ldr_d     = 1'b0;
        addr_d    = addr_q;
        din_d     = din_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        grant_upd = 1'b0;
        sel_we    = grant ? we1 : we0;

        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    state_d   = StAccess;
                    owner_d   = grant;
                    grant_upd = 1'b1;
                    addr_d    = grant ? addr1 : addr0;
                    // Strobes for the ACCESS cycle are registered here, at the grant edge.
                    if (sel_we) begin
                        en_d  = 1'b1;
                        str_d = 1'b1;
                        din_d = grant ? wdata1 : wdata0;
                    end else begin
                        ldr_d = 1'b1;
                    end
                end
            end
            StAccess: begin
                state_d = StAck;
                if (ldr_q) begin
                    if (owner_q == PORT_DMA) begin
                        rdata1_d = ram_dout;
                    end else begin
                        rdata0_d = ram_dout;
                    end
                end
                ack0_d = (owner_q == PORT_CPU);
                ack1_d = (owner_q == PORT_DMA);
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= PORT_CPU;
            en_q     <= 1'b0;
            str_q    <= 1'b0;
            ldr_q    <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            en_q     <= en_d;
            str_q    <= str_d;
            ldr_q    <= ldr_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign busy       = (state_q != StIdle);
    assign ram_enable = en_q;
    assign ram_str    = str_q;
    assign ram_ldr    = ldr_q;
    assign ram_addr   = addr_q;
    assign ram_din    = din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by randomized two-port traffic.
module tb_ram_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1, ram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, ram_din, ram_dout;
    logic          ack0, ack1, busy, ram_enable, ram_str, ram_ldr;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .busy       (busy),
        .ram_enable (ram_enable),
        .ram_str    (ram_str),
        .ram_ldr    (ram_ldr),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Behavioural 1024 x 8 RAM: write at the edge, combinational read while ldr.
    logic [DW-1:0] mem [1024];
    logic          ram_clear;

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ram_enable && ram_str) begin
            mem[ram_addr] <= ram_din;
        end
    end

    assign ram_dout = ram_ldr ? mem[ram_addr] : 8'hEE;

    int checks;
    int errors;
    int cyc;

    // Reference model state: one outstanding transaction, 3 cycles per grant.
    int            next_free;
    int            g_cycle;
    bit            g_valid, g_port, g_we, last;
    logic [AW-1:0] g_addr, exp_addr;
    logic [DW-1:0] g_wdata, exp_din;
    logic [DW-1:0] exp_rd [2];
    logic [DW-1:0] exp_mem [1024];
    bit            acked [2];

    logic          d_rst;
    logic          d_req [2];
    logic          d_we [2];
    logic [AW-1:0] d_addr [2];
    logic [DW-1:0] d_wdata [2];

    int lat, guard, nack;
    int ord [4];
    int acyc [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 10'h3FF;
            2:       return 10'h123;
            3:       return 10'h050;
            default: return AW'($urandom_range(0, 1023));
        endcase
    endfunction

    // At each rising edge: decide whether a grant happens and who wins.
    task automatic model_edge();
        if (!rst) begin
            g_valid   = 1'b0;
            last      = 1'b1;
            next_free = 0;
            exp_addr  = '0;
            exp_din   = '0;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            return;
        end
        if (cyc >= next_free && (req0 || req1)) begin
            g_port    = (req0 && req1) ? ~last : req1;
            last      = g_port;
            g_we      = g_port ? we1 : we0;
            g_addr    = g_port ? addr1 : addr0;
            g_wdata   = g_port ? wdata1 : wdata0;
            g_cycle   = cyc;
            g_valid   = 1'b1;
            next_free = cyc + 3;
            exp_addr  = g_addr;
            if (g_we) exp_din = g_wdata;
        end
    endtask

    // Mid-cycle: compare every output against what the model says this cycle holds.
    task automatic model_check();
        bit in_access, in_ack;
        in_access = g_valid && (cyc == g_cycle);
        in_ack    = g_valid && (cyc == g_cycle + 1);
        if (in_ack) begin
            if (g_we) exp_mem[g_addr] = g_wdata;
            else      exp_rd[g_port] = exp_mem[g_addr];
            acked[g_port] = 1'b1;
        end
        chk("ack0", 32'(ack0), 32'(in_ack && !g_port));
        chk("ack1", 32'(ack1), 32'(in_ack && g_port));
        chk("ram_enable", 32'(ram_enable), 32'(in_access && g_we));
        chk("ram_str", 32'(ram_str), 32'(in_access && g_we));
        chk("ram_ldr", 32'(ram_ldr), 32'(in_access && !g_we));
        chk("busy", 32'(busy), 32'(in_access || in_ack));
        chk("ram_addr", 32'(ram_addr), 32'(exp_addr));
        chk("ram_din", 32'(ram_din), 32'(exp_din));
        chk("rdata0", 32'(rdata0), 32'(exp_rd[0]));
        chk("rdata1", 32'(rdata1), 32'(exp_rd[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        rst    = d_rst;
        req0   = d_req[0];
        req1   = d_req[1];
        we0    = d_we[0];
        we1    = d_we[1];
        addr0  = d_addr[0];
        addr1  = d_addr[1];
        wdata0 = d_wdata[0];
        wdata1 = d_wdata[1];
        @(negedge clk);
        model_check();
    endtask

    task automatic access(input bit p, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, output int n);
        d_req[p]   = 1'b1;
        d_we[p]    = we;
        d_addr[p]  = a;
        d_wdata[p] = wd;
        acked[p]   = 1'b0;
        n = 0;
        while (!acked[p] && n < 12) begin
            tick();
            n++;
        end
        chk("ack_seen", 32'(acked[p]), 32'd1);
        d_req[p] = 1'b0;
        acked[p] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        ram_clear = 1'b1;
        rst = 1'b0;
        {req0, req1, we0, we1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        d_rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            d_req[p] = 1'b0; d_we[p] = 1'b0; d_addr[p] = '0; d_wdata[p] = '0;
            acked[p] = 1'b0; exp_rd[p] = '0;
        end
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        g_valid = 1'b0; g_port = 1'b0; g_we = 1'b0; last = 1'b1;
        g_addr = '0; g_wdata = '0; exp_addr = '0; exp_din = '0;
        next_free = 0; g_cycle = 0;

        // Reset held for 3 cycles with a CPU read pending.
        d_req[0] = 1'b1; d_addr[0] = 10'h010;
        tick();
        ram_clear = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        d_rst = 1'b1;
        tick();
        tick();
        chk("rst_first_grant_ldr", 32'(ram_ldr), 32'd1);
        chk("rst_first_grant_addr", 32'(ram_addr), 32'h010);
        tick();
        chk("rst_first_ack0", 32'(ack0), 32'd1);
        d_req[0] = 1'b0;
        acked[0] = 1'b0;

        // Single write then read from the CPU port.
        access(1'b0, 1'b1, 10'h123, 8'hA5, lat);
        chk("wr_latency", 32'(lat), 32'd3);
        access(1'b0, 1'b0, 10'h123, 8'h00, lat);
        chk("rd_latency", 32'(lat), 32'd3);
        chk("rd_0x123", 32'(rdata0), 32'hA5);

        // Address extremes.
        access(1'b1, 1'b1, 10'h000, 8'h3C, lat);
        access(1'b0, 1'b1, 10'h3FF, 8'hFF, lat);
        access(1'b1, 1'b1, 10'h000, 8'h00, lat);
        access(1'b0, 1'b0, 10'h3FF, 8'h00, lat);
        chk("rd_0x3ff", 32'(rdata0), 32'hFF);
        access(1'b1, 1'b0, 10'h000, 8'h00, lat);
        chk("rd_0x000", 32'(rdata1), 32'h00);

        // DMA back-to-back: req held through ACK with new data, no duplicate grant.
        access(1'b1, 1'b1, 10'h040, 8'h9C, lat);
        chk("b2b_first_latency", 32'(lat), 32'd3);
        access(1'b1, 1'b0, 10'h040, 8'h00, lat);
        chk("b2b_second_latency", 32'(lat), 32'd3);
        chk("b2b_rdata1", 32'(rdata1), 32'h9C);

        // Contention after DMA was served last: order must alternate starting at CPU.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'h200; d_wdata[0] = 8'($urandom);
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 10'h200;
        acked[0] = 1'b0; acked[1] = 1'b0;
        nack = 0;
        guard = 0;
        while (nack < 4 && guard < 30) begin
            tick();
            guard++;
            if (ack0 || ack1) begin
                ord[nack]  = int'(ack1);
                acyc[nack] = cyc;
                nack++;
            end
            for (int p = 0; p < 2; p++) begin
                if (acked[p]) begin
                    acked[p] = 1'b0;
                    d_wdata[p] = 8'($urandom);
                end
            end
        end
        d_req[0] = 1'b0;
        d_req[1] = 1'b0;
        chk("cont_acks", 32'(nack), 32'd4);
        for (int k = 0; k < nack; k++) begin
            chk("cont_order", 32'(ord[k]), 32'(k % 2));
            if (k > 0) chk("cont_spacing", 32'(acyc[k] - acyc[k-1]), 32'd3);
        end
        tick();
        tick();

        // Reset during the ACCESS cycle of a write must abort it.
        access(1'b0, 1'b1, 10'h050, 8'h11, lat);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 10'h050; d_wdata[0] = 8'h77;
        guard = 0;
        while (!(g_valid && g_cycle == cyc) && guard < 10) begin
            tick();
            guard++;
        end
        chk("mid_str_before", 32'(ram_str), 32'd1);
        rst = 1'b0;
        d_rst = 1'b0;
        d_req[0] = 1'b0;
        #1;
        chk("mid_str_drop", 32'(ram_str), 32'd0);
        chk("mid_en_drop", 32'(ram_enable), 32'd0);
        chk("mid_busy_drop", 32'(busy), 32'd0);
        tick();
        tick();
        d_rst = 1'b1;
        tick();
        access(1'b0, 1'b0, 10'h050, 8'h00, lat);
        chk("mid_rd_0x050", 32'(rdata0), 32'h11);

        // Randomized traffic from both ports.
        acked[0] = 1'b0; acked[1] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!d_req[p] || acked[p]) begin
                    acked[p]   = 1'b0;
                    d_req[p]   = ($urandom_range(0, 2) != 0);
                    d_we[p]    = 1'($urandom_range(0, 1));
                    d_addr[p]  = rand_addr();
                    d_wdata[p] = 8'($urandom);
                end
            end
            tick();
        end
        d_req[0] = 1'b0;
        d_req[1] = 1'b0;
        for (int c = 0; c < 5; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
